// File: rtl/updown_cntr_sequencer.sv
// ============================================================================
// updown_cntr_sequencer
// ----------------------------------------------------------------------------
// Command-driven controller for the 3-bit up/down counter datapath. Commands
// (LOAD / UP / DOWN / BOUNCE) arrive over a valid/ready handshake and are
// turned into a cycle-accurate sequence of counter pin activity. A shadow copy
// of the count is kept so observers never need to read the counter itself.
//
// Optional feature:
//   UDSEQ_ABORT_EN  - when defined, adds an 'abort' input that cuts a running
//                     UP/DOWN/BOUNCE command short. Undefined: no abort port,
//                     every command runs to completion.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted (high only while idle)
//   cmd_op     in   2'b00 LOAD, 2'b01 UP, 2'b10 DOWN, 2'b11 BOUNCE
//   cmd_arg    in   LOAD value / BOUNCE upper bound (ignored for UP/DOWN)
//   cmd_steps  in   number of count enables to issue (ignored for LOAD)
//   abort      in   (UDSEQ_ABORT_EN only) stop a running command
//   cnt_data   out  counter data_in
//   cnt_ld     out  counter ld_cnt
//   cnt_updn   out  counter updn_cnt (1 = up, 0 = down)
//   cnt_enb    out  counter count_enb
//   shadow     out  counter value after the most recently issued operation
//   busy       out  high whenever a command is in progress
//   done       out  one-cycle completion pulse
//   wrap       out  one-cycle pulse alongside an enable that wraps the count
//
// Timing: the command is accepted on edge T. All outputs are registers loaded
// on that same edge from next-state logic, so the first cnt_ld/cnt_enb is
// visible in cycle T+1 and done in cycle T+1+N (T+2 for LOAD, T+1 for
// commands that issue no enables).
// ============================================================================
module updown_cntr_sequencer #(
    parameter int WIDTH  = 3,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_arg,
    input  logic [STEP_W-1:0] cmd_steps,
`ifdef UDSEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic [WIDTH-1:0]  cnt_data,
    output logic              cnt_ld,
    output logic              cnt_updn,
    output logic              cnt_enb,
    output logic [WIDTH-1:0]  shadow,
    output logic              busy,
    output logic              done,
    output logic              wrap
);

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_UP     = 2'b01,
        OP_DOWN   = 2'b10,
        OP_BOUNCE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    state_e state_q, state_n;

    // Registered command context.
    logic [WIDTH-1:0]  arg_q,    arg_n;
    logic              bounce_q, bounce_n;
    logic [STEP_W-1:0] steps_q,  steps_n;   // enables still to issue after the current one
    logic              dir_q,    dir_n;     // direction of the next enable

    // Next values of the registered outputs.
    logic [WIDTH-1:0]  shadow_n;
    logic [WIDTH-1:0]  cnt_data_n;
    logic              cnt_ld_n;
    logic              cnt_updn_n;
    logic              cnt_enb_n;
    logic              done_n;
    logic              wrap_n;
    logic              busy_n;
    logic              cmd_ready_n;

    // Single step datapath shared by the first enable (issued from IDLE)
    // and all following enables (issued from RUN).
    logic              step_issue;
    logic              step_dir;

    logic              abort_hit;

`ifdef UDSEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n     = state_q;
        arg_n       = arg_q;
        bounce_n    = bounce_q;
        steps_n     = steps_q;
        dir_n       = dir_q;
        shadow_n    = shadow;
        cnt_data_n  = '0;
        cnt_ld_n    = 1'b0;
        cnt_updn_n  = 1'b0;
        cnt_enb_n   = 1'b0;
        done_n      = 1'b0;
        wrap_n      = 1'b0;
        step_issue  = 1'b0;
        step_dir    = dir_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    arg_n    = cmd_arg;
                    bounce_n = (op_e'(cmd_op) == OP_BOUNCE);
                    if (op_e'(cmd_op) == OP_LOAD) begin
                        state_n    = S_LOAD;
                        cnt_ld_n   = 1'b1;
                        cnt_data_n = cmd_arg;
                        shadow_n   = cmd_arg;
                    end else if ((cmd_steps == '0) ||
                                 ((op_e'(cmd_op) == OP_BOUNCE) && (cmd_arg == '0))) begin
                        // Nothing to issue: complete straight away.
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n    = S_RUN;
                        steps_n    = cmd_steps - 1'b1;
                        step_issue = 1'b1;
                        unique case (op_e'(cmd_op))
                            OP_UP:   step_dir = 1'b1;
                            OP_DOWN: step_dir = 1'b0;
                            default: step_dir = (shadow < cmd_arg);
                        endcase
                    end
                end
            end

            S_LOAD: begin
                state_n = S_DONE;
                done_n  = 1'b1;
            end

            S_RUN: begin
                if (abort_hit || (steps_q == '0)) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end else begin
                    steps_n    = steps_q - 1'b1;
                    step_issue = 1'b1;
                    step_dir   = dir_q;
                end
            end

            S_DONE: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (step_issue) begin
            cnt_enb_n  = 1'b1;
            cnt_updn_n = step_dir;
            dir_n      = step_dir;
            if (step_dir) begin
                shadow_n = shadow + 1'b1;
                wrap_n   = (shadow == '1);
            end else begin
                shadow_n = shadow - 1'b1;
                wrap_n   = (shadow == '0);
            end
            // BOUNCE turns around at its bounds, so it can never wrap.
            if (bounce_n) begin
                if (shadow_n == arg_n) begin
                    dir_n = 1'b0;
                end else if (shadow_n == '0) begin
                    dir_n = 1'b1;
                end
            end
        end

        busy_n      = (state_n != S_IDLE);
        cmd_ready_n = (state_n == S_IDLE);
    end

    // ------------------------------------------------------------------------
    // Command context and output registers
    // ------------------------------------------------------------------------
    // cmd_ready resets high: the sequencer is idle and ready the moment
    // reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arg_q     <= '0;
            bounce_q  <= 1'b0;
            steps_q   <= '0;
            dir_q     <= 1'b0;
            shadow    <= '0;
            cnt_data  <= '0;
            cnt_ld    <= 1'b0;
            cnt_updn  <= 1'b0;
            cnt_enb   <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            arg_q     <= arg_n;
            bounce_q  <= bounce_n;
            steps_q   <= steps_n;
            dir_q     <= dir_n;
            shadow    <= shadow_n;
            cnt_data  <= cnt_data_n;
            cnt_ld    <= cnt_ld_n;
            cnt_updn  <= cnt_updn_n;
            cnt_enb   <= cnt_enb_n;
            done      <= done_n;
            wrap      <= wrap_n;
            busy      <= busy_n;
            cmd_ready <= cmd_ready_n;
        end
    end

endmodule

// File: tb/tb_updown_cntr_sequencer.sv
// ============================================================================
// tb_updown_cntr_sequencer
// ----------------------------------------------------------------------------
// Directed plus randomized bench. For each command a behavioural model builds
// the full expected per-cycle trace (counter pins, shadow, pulses, handshake)
// from the command rules using plain modular arithmetic; the bench then
// compares the DUT against that trace cycle by cycle on the falling edge.
// Define UDSEQ_ABORT_EN to also exercise the abort input.
// ============================================================================
module tb_updown_cntr_sequencer;

    localparam int W   = 3;
    localparam int SW  = 4;
    localparam int MOD = 1 << W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [W-1:0]  cmd_arg = '0;
    logic [SW-1:0] cmd_steps = '0;
`ifdef UDSEQ_ABORT_EN
    logic          abort = 1'b0;
`endif
    logic [W-1:0]  cnt_data;
    logic          cnt_ld;
    logic          cnt_updn;
    logic          cnt_enb;
    logic [W-1:0]  shadow;
    logic          busy;
    logic          done;
    logic          wrap;

    updown_cntr_sequencer #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cmd_steps (cmd_steps),
`ifdef UDSEQ_ABORT_EN
        .abort     (abort),
`endif
        .cnt_data  (cnt_data),
        .cnt_ld    (cnt_ld),
        .cnt_updn  (cnt_updn),
        .cnt_enb   (cnt_enb),
        .shadow    (shadow),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Expected value of every observable output for one cycle.
    typedef struct packed {
        logic         ld;
        logic [W-1:0] data;
        logic         enb;
        logic         updn;
        logic [W-1:0] shdw;
        logic         wrp;
        logic         dn;
        logic         bsy;
        logic         rdy;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    int   m_shadow = 0;     // model's idea of the counter value
    exp_t exp_q[$];

    // cnt_data only carries meaning while loading, cnt_updn only while
    // enabling; elsewhere they are not compared.
    function automatic exp_t sample(input exp_t e);
        exp_t o;
        o.ld   = cnt_ld;
        o.data = e.ld ? cnt_data : '0;
        o.enb  = cnt_enb;
        o.updn = e.enb ? cnt_updn : 1'b0;
        o.shdw = shadow;
        o.wrp  = wrap;
        o.dn   = done;
        o.bsy  = busy;
        o.rdy  = cmd_ready;
        return o;
    endfunction

    task automatic check_exp(input string tag, input exp_t e);
        exp_t o;
        o = sample(e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (ld,data,enb,updn,shadow,wrap,done,busy,ready)",
                   tag, o, e);
        end
    endtask

    task automatic check_zero(input string tag);
        logic [W+W+5:0] o;
        o = {cnt_ld, cnt_data, cnt_enb, cnt_updn, shadow, wrap, done, busy};
        checks++;
        assert (o === '0) else begin
            failures++;
            $error("FAIL %s observed=%b expected=all-zero", tag, o);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e      = '0;
        e.rdy  = 1'b1;
        e.shdw = W'(m_shadow);
        return e;
    endfunction

    // Builds the trace seen in cycles T+1, T+2, ... after the accept edge,
    // ending with the first idle cycle. abort_at = k stops after the k-th
    // enable (0 = never).
    task automatic model_cmd(input int op, input int arg, input int steps, input int abort_at);
        exp_t e;
        int   dir;
        exp_q.delete();
        if (op == 0) begin
            e       = '0;
            e.ld    = 1'b1;
            e.data  = W'(arg);
            m_shadow = arg;
            e.shdw  = W'(m_shadow);
            e.bsy   = 1'b1;
            exp_q.push_back(e);
        end else if (!(steps == 0 || (op == 3 && arg == 0))) begin
            if (op == 1)      dir = 1;
            else if (op == 2) dir = 0;
            else              dir = (m_shadow < arg) ? 1 : 0;
            for (int i = 1; i <= steps; i++) begin
                e      = '0;
                e.enb  = 1'b1;
                e.updn = 1'(dir);
                if (dir == 1) begin
                    e.wrp    = (m_shadow == MOD - 1);
                    m_shadow = (m_shadow + 1) % MOD;
                end else begin
                    e.wrp    = (m_shadow == 0);
                    m_shadow = (m_shadow + MOD - 1) % MOD;
                end
                e.shdw = W'(m_shadow);
                e.bsy  = 1'b1;
                exp_q.push_back(e);
                if (op == 3) begin
                    if (m_shadow == arg)  dir = 0;
                    else if (m_shadow == 0) dir = 1;
                end
                if (i == abort_at) break;
            end
        end
        e      = '0;
        e.dn   = 1'b1;
        e.bsy  = 1'b1;
        e.shdw = W'(m_shadow);
        exp_q.push_back(e);
        exp_q.push_back(idle_exp());
    endtask

    // Issues one command and checks the whole resulting trace. 'hold' keeps
    // cmd_valid high (with scrambled fields) while the sequencer is busy.
    // rst_at = k asserts reset during the k-th trace cycle and ends the command.
    task automatic run_cmd(input int op, input int arg, input int steps,
                           input bit hold, input int abort_at, input int rst_at);
        int guard;
        bit stop;
        @(negedge clk);
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        assert (cmd_ready === 1'b1) else begin
            failures++;
            $error("FAIL ready_wait observed=%b expected=1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_arg   = W'(arg);
        cmd_steps = SW'(steps);
        model_cmd(op, arg, steps, abort_at);
        @(posedge clk);
        #1;
        cmd_valid = hold;
        stop = 1'b0;
        for (int i = 0; i < exp_q.size() && !stop; i++) begin
            @(negedge clk);
            check_exp($sformatf("op%0d_arg%0d_steps%0d_cyc%0d", op, arg, steps, i), exp_q[i]);
            if (hold) begin
                cmd_op    = 2'($urandom);
                cmd_arg   = W'($urandom);
                cmd_steps = SW'($urandom);
                if (exp_q[i].dn) cmd_valid = 1'b0;
            end
`ifdef UDSEQ_ABORT_EN
            abort = (abort_at != 0 && i == abort_at - 1);
`endif
            if (rst_at != 0 && i == rst_at - 1) begin
                rst = 1'b1;
                #1;
                check_zero("reset_mid_run_async");
                stop = 1'b1;
            end
        end
        cmd_valid = 1'b0;
`ifdef UDSEQ_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    initial begin
        // Power-on reset.
        #2 rst = 1'b1;
        @(negedge clk);
        check_zero("reset_hold");
        @(negedge clk);
        rst = 1'b0;
        m_shadow = 0;
        @(negedge clk);
        check_exp("after_reset_idle", idle_exp());

        // LOAD 5: single load cycle, done at T+2.
        run_cmd(0, 5, 0, 1'b0, 0, 0);
        // LOAD 6 then UP 3: 7,0,1 with wrap on the 2nd enable.
        run_cmd(0, 6, 0, 1'b0, 0, 0);
        run_cmd(1, 0, 3, 1'b0, 0, 0);
        // LOAD 1, DOWN 2: 0,7 with wrap; then UP 0 completes immediately.
        run_cmd(0, 1, 0, 1'b0, 0, 0);
        run_cmd(2, 0, 2, 1'b0, 0, 0);
        run_cmd(1, 0, 0, 1'b0, 0, 0);
        // LOAD 0, BOUNCE arg=2 steps=6: 1,2,1,0,1,2 never wrapping.
        run_cmd(0, 0, 0, 1'b0, 0, 0);
        run_cmd(3, 2, 6, 1'b0, 0, 0);
        // BOUNCE with zero bound issues nothing.
        run_cmd(3, 0, 5, 1'b0, 0, 0);
        // Maximum step count with cmd_valid held throughout: no re-acceptance.
        run_cmd(2, 0, 15, 1'b1, 0, 0);

        // Reset on the 2nd enable of UP 5.
        run_cmd(1, 0, 5, 1'b0, 0, 2);
        @(negedge clk);
        check_zero("reset_mid_run_held");
        rst = 1'b0;
        m_shadow = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_exp($sformatf("post_reset_idle%0d", i), idle_exp());
        end

`ifdef UDSEQ_ABORT_EN
        // Abort on the 2nd enable of UP 7 with cmd_valid held while busy.
        run_cmd(1, 0, 7, 1'b1, 2, 0);
        // Abort on the last enable is the same as normal completion.
        run_cmd(3, 5, 3, 1'b0, 3, 0);
`endif

        // Randomized commands.
        for (int n = 0; n < 60; n++) begin
            int op;
            int arg;
            int steps;
            op    = int'($urandom_range(0, 3));
            arg   = int'($urandom_range(0, MOD - 1));
            steps = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, (1 << SW) - 1));
`ifdef UDSEQ_ABORT_EN
            run_cmd(op, arg, steps, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0, 0);
`else
            run_cmd(op, arg, steps, 1'($urandom_range(0, 1)), 0, 0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updown_cntr_sequencer.md
Name: updown_cntr_sequencer

Overview:
- Command-driven controller that sequences the 3-bit up/down counter datapath.
- Accepts load/count/bounce commands over a valid/ready handshake.
- Drives the counter's data_in, ld_cnt, updn_cnt and count_enb pins.
- Keeps a shadow copy of the count so software/test logic can observe progress without reading the counter.

Parameters:
- WIDTH, 3, counter data width (data_in/data_out/shadow).
- STEP_W, 4, width of the step-count field (max 2^STEP_W-1 steps per command).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command (high only in IDLE).
- cmd_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 BOUNCE.
- cmd_arg  input  WIDTH  LOAD value / BOUNCE upper bound; ignored for UP/DOWN.
- cmd_steps  input  STEP_W  number of count enables to issue; ignored for LOAD.
- cnt_data  output  WIDTH  to counter data_in.
- cnt_ld  output  1  to counter ld_cnt, active-high.
- cnt_updn  output  1  to counter updn_cnt, 1=up, 0=down.
- cnt_enb  output  1  to counter count_enb, active-high.
- shadow  output  WIDTH  mirror of counter value after each issued operation.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse when a command completes.
- wrap  output  1  one-cycle pulse, coincident with the cnt_enb that wraps 7->0 or 0->7.

Behaviour:
- Reset (async, any time, including mid-command): state=IDLE. cnt_ld, cnt_enb, cnt_updn, cnt_data, shadow, done, wrap, busy = 0; cmd_ready=1 once rst deasserts. Any in-flight command is discarded.
- Accept: a command is taken on a clock edge with cmd_valid && cmd_ready. Fields are registered; cmd_ready drops the following cycle.
- States: IDLE, LOAD, RUN, DONE.
- IDLE -> LOAD (op 00), or IDLE -> RUN (op 01/10/11 with steps != 0).
- IDLE -> DONE (op 01/10/11 with steps==0, or BOUNCE with arg==0). No enables are issued on this path.
- LOAD: exactly one cycle with cnt_ld=1, cnt_data=arg, cnt_enb=0; shadow<=arg; next DONE.
- RUN: one cnt_enb=1 per cycle, back-to-back, for exactly steps cycles. Shadow updates mod 2^WIDTH on each enable. After the last enable, go to DONE.
- UP/DOWN: cnt_updn fixed at 1 or 0 respectively for the whole command.
- BOUNCE initial direction: up if shadow<arg, else down.
- BOUNCE reversal: after a step, if shadow==arg set dir=down; if shadow==0 set dir=up. cnt_updn reflects dir in the same cycle as cnt_enb. BOUNCE never wraps.
- DONE: done=1 for one cycle; next IDLE; cmd_ready=1 again the cycle after DONE.
- Latency: accept edge at cycle T; first cnt_ld/cnt_enb at T+1; done at T+1+N for N steps (T+2 for LOAD, T+1 for zero-step commands).
- cnt_ld and cnt_enb are never high together. Both are 0 outside LOAD/RUN.
- cmd_valid while busy is ignored and is not queued; the requester must hold cmd_valid until accepted.
- All outputs are registered.

Optional Feature:
- Macro UDSEQ_ABORT_EN.
- Defined: adds input abort (1 bit). abort high in RUN stops enables from the next cycle, moves to DONE, and done pulses. shadow holds the last issued value. abort in IDLE/LOAD/DONE has no effect.
- Undefined: no abort port; commands always run to completion.

Test Plan:
- Reset mid-RUN: UP steps=5, assert rst on 2nd enable -> all outputs 0 immediately (async), IDLE, cmd_ready=1 after release, no further cnt_enb.
- LOAD arg=5 -> cnt_ld=1 with cnt_data=5 for exactly one cycle at T+1, shadow=5, done at T+2.
- LOAD 6 then UP steps=3 -> three cnt_enb with cnt_updn=1; shadow 7,0,1; wrap pulses on the 2nd enable; done after the 3rd.
- LOAD 1, DOWN steps=2 -> shadow 0 then 7, wrap on 2nd enable; then UP steps=0 -> done at T+1 with no cnt_enb.
- LOAD 0, BOUNCE arg=2 steps=6 -> shadow 1,2,1,0,1,2; cnt_updn 1,1,0,0,1,1; wrap never asserted.
- cmd_valid held while busy -> cmd_ready=0 and no acceptance; with UDSEQ_ABORT_EN, abort on 2nd enable of UP steps=7 -> no further enables, done next cycle.
